// File: rtl/sdram_cmd_sequencer_if.sv
// Bus and SDRAM-side signal bundle for the closed-page command sequencer.
// master drives requests; slave is the sequencer.
interface sdram_cmd_sequencer_if;
  logic       Req;
  logic       We;
  logic [2:0] BurstLengthConfig;
  logic       RowAddrLd;
  logic       ColAddrLd;
  logic       ColCounterEn;
  logic       CmdCsN;
  logic       CmdRasN;
  logic       CmdCasN;
  logic       CmdWeN;
  logic       DataValid;
  logic       DataAccept;
  logic       Ack;
  logic       Busy;

  modport master (
    output Req, We, BurstLengthConfig,
    input  RowAddrLd, ColAddrLd, ColCounterEn,
    input  CmdCsN, CmdRasN, CmdCasN, CmdWeN,
    input  DataValid, DataAccept, Ack, Busy
  );

  modport slave (
    input  Req, We, BurstLengthConfig,
    output RowAddrLd, ColAddrLd, ColCounterEn,
    output CmdCsN, CmdRasN, CmdCasN, CmdWeN,
    output DataValid, DataAccept, Ack, Busy
  );
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// Closed-page SDRAM command sequencer: ACT / RD|WR burst / PRE per access,
// periodic auto-refresh, all outputs registered.
module sdram_cmd_sequencer #(
  parameter int T_RCD        = 2,
  parameter int CAS_LAT      = 2,
  parameter int T_WR         = 1,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 6,
  parameter int REF_INTERVAL = 780
) (
  input logic Clk,
  input logic Rst,
  sdram_cmd_sequencer_if.slave bus
);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam int RCD_N = (T_RCD > 1) ? T_RCD - 2 : 0;
  localparam int WR_N  = (T_WR > 0)  ? T_WR - 1  : 0;
  localparam int RP_N  = (T_RP > 1)  ? T_RP - 2  : 0;
  localparam int RFC_N = (T_RFC > 1) ? T_RFC - 2 : 0;

  localparam logic [15:0] RCD_LD = 16'(RCD_N);
  localparam logic [15:0] WR_LD  = 16'(WR_N);
  localparam logic [15:0] RP_LD  = 16'(RP_N);
  localparam logic [15:0] RFC_LD = 16'(RFC_N);
  localparam logic [15:0] REF_LD = 16'(REF_INTERVAL - 1);

  localparam logic [CAS_LAT-1:0] LOW_MASK = {CAS_LAT{1'b1}} >> 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_RCD,
    S_COL,
    S_CASW,
    S_WRREC,
    S_PRE,
    S_RP,
    S_REF,
    S_RFC
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  bl_q, bl_d;
  logic [2:0]  bl_cfg;
  logic        first_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d;
  logic        ref_tick;
  logic [CAS_LAT-1:0] sr_q, sr_d;
  logic        rd_now;

  logic [3:0] cmd_q, cmd_d;
  logic rald_q, rald_d;
  logic cald_q, cald_d;
  logic cen_q, cen_d;
  logic da_q, da_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;

  assign ref_tick = (ref_cnt_q == 16'd0);
  assign rd_now   = (state_q == S_COL) && !we_q;

  // Beats-minus-one from the request's burst-length code.
  always_comb begin
    bl_cfg = 3'd7;
    unique case (bus.BurstLengthConfig)
      3'd0:    bl_cfg = 3'd0;
      3'd1:    bl_cfg = 3'd1;
      3'd2:    bl_cfg = 3'd3;
      default: bl_cfg = 3'd7;
    endcase
  end

  // State register, timers, CAS pipeline and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      bl_q       <= '0;
      ref_cnt_q  <= REF_LD;
      ref_pend_q <= 1'b0;
      sr_q       <= '0;
      cmd_q      <= CMD_DESEL;
      rald_q     <= 1'b0;
      cald_q     <= 1'b0;
      cen_q      <= 1'b0;
      da_q       <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      bl_q       <= bl_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      sr_q       <= sr_d;
      cmd_q      <= cmd_d;
      rald_q     <= rald_d;
      cald_q     <= cald_d;
      cen_q      <= cen_d;
      da_q       <= da_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  // Refresh timer, pending flag and read-latency shift register.
  always_comb begin
    ref_cnt_d  = ref_tick ? REF_LD : ref_cnt_q - 16'd1;
    ref_pend_d = ref_tick | (ref_pend_q & (state_q != S_REF));
    sr_d       = sr_q << 1;
    sr_d[0]    = rd_now;
  end

  // Next-state logic; an expiry seen in IDLE counts as pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bl_d    = bl_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ref_pend_q || ref_tick) begin
          state_d = S_REF;
        end else if (bus.Req) begin
          we_d    = bus.We;
          bl_d    = bl_cfg;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        if (T_RCD <= 1) begin
          state_d = S_COL;
          cnt_d   = {13'd0, bl_q};
          first_d = 1'b1;
        end else begin
          state_d = S_RCD;
          cnt_d   = RCD_LD;
        end
      end
      S_RCD: begin
        if (cnt_q == 16'd0) begin
          state_d = S_COL;
          cnt_d   = {13'd0, bl_q};
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_COL: begin
        if (cnt_q == 16'd0) begin
          if (!we_q) begin
            state_d = S_CASW;
          end else if (T_WR == 0) begin
            state_d = S_PRE;
          end else begin
            state_d = S_WRREC;
            cnt_d   = WR_LD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CASW: begin
        if ((sr_q & LOW_MASK) == '0) begin
          state_d = S_PRE;
        end
      end
      S_WRREC: begin
        if (cnt_q == 16'd0) begin
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PRE: begin
        if (T_RP <= 1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RP;
          cnt_d   = RP_LD;
        end
      end
      S_RP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_REF: begin
        if (T_RFC <= 1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RFC;
          cnt_d   = RFC_LD;
        end
      end
      S_RFC: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so pins line up with the state.
  always_comb begin
    cmd_d  = CMD_NOP;
    rald_d = 1'b0;
    cald_d = 1'b0;
    cen_d  = 1'b0;
    da_d   = 1'b0;
    ack_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_ACT: begin
        cmd_d  = CMD_ACT;
        rald_d = 1'b1;
      end
      S_COL: begin
        cmd_d  = we_d ? CMD_WR : CMD_RD;
        cen_d  = 1'b1;
        cald_d = first_d;
        da_d   = we_d;
      end
      S_PRE: begin
        cmd_d = CMD_PRE;
        ack_d = 1'b1;
      end
      S_REF:   cmd_d = CMD_REF;
      default: cmd_d = CMD_NOP;
    endcase
  end

  assign bus.CmdCsN       = cmd_q[3];
  assign bus.CmdRasN      = cmd_q[2];
  assign bus.CmdCasN      = cmd_q[1];
  assign bus.CmdWeN       = cmd_q[0];
  assign bus.RowAddrLd    = rald_q;
  assign bus.ColAddrLd    = cald_q;
  assign bus.ColCounterEn = cen_q;
  assign bus.DataValid    = sr_q[CAS_LAT-1];
  assign bus.DataAccept   = da_q;
  assign bus.Ack          = ack_q;
  assign bus.Busy         = busy_q;

endmodule
